// File: rtl/data_mem_sweep.sv
// data_mem_sweep: single-port synchronous data memory for the 8-bit RISC core.
// Registered read/write-return path with a one-cycle valid strobe and an
// optional reset-time sweep that zeroes every word before the block reports ready.
//
// Parameters:
//   DATA_W     word width in bits
//   ADDR_W     address width, depth = 2**ADDR_W words
//   CLR_ON_RST 1 = zero all words after reset, 0 = ready right after reset
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       access request, accepted only while ready
//   wr_en     1 = write, 0 = read
//   addr      word address
//   data_in   write data
//   data_out  registered read data / write-return data
//   rvalid    data_out valid this cycle
//   ready     block accepts requests
//   perr      parity error on current data_out (0 unless DMEM_PARITY_EN)
//   inj_perr  store an inverted parity bit on this write (DMEM_PARITY_EN only)
//
// Optional feature: define DMEM_PARITY_EN to add one even-parity bit per word.
module data_mem_sweep #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              ready,
    output logic              perr,
    input  logic              inj_perr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RST   = CLR_ON_RST ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_d;
    logic              rvalid_d;
    logic              ready_d;
    logic              perr_d;

    logic              accept_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              rd_perr_c;

    assign accept_c = req && ready;

    // Next-state, memory write port and output next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_out;
        rvalid_d    = 1'b0;
        ready_d     = ready;
        perr_d      = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr;
        mem_wdata_c = data_in;

        case (state_q)
            ST_CLEAR: begin
                // One zero word per cycle; requests are ignored meanwhile
                ready_d     = 1'b0;
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = '0;
                cnt_d       = cnt_q + ADDR_W'(1);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    rvalid_d = 1'b1;
                    if (wr_en) begin
                        // Write-first return: echo the stored data
                        mem_we_c = 1'b1;
                        data_d   = data_in;
                    end else begin
                        data_d = mem[addr];
                        perr_d = rd_perr_c;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RST;
            cnt_q    <= '0;
            data_out <= '0;
            rvalid   <= 1'b0;
            ready    <= 1'b0;
            perr     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_out <= data_d;
            rvalid   <= rvalid_d;
            ready    <= ready_d;
            perr     <= perr_d;
        end
    end

    // Storage array, no reset: contents are defined only by the sweep or writes
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic wpar_c;

    // Sweep writes parity of zero (0); run writes ^data, optionally inverted
    assign wpar_c    = (state_q == ST_RUN) && ((^data_in) ^ inj_perr);
    assign rd_perr_c = par_mem[addr] ^ (^mem[addr]);

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            par_mem[mem_waddr_c] <= wpar_c;
        end
    end
`else
    logic unused_inj_perr;

    assign unused_inj_perr = inj_perr;
    assign rd_perr_c       = 1'b0;
`endif

endmodule
